spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Frame decoder sitting directly downstream of the FPGA SPI slave. It consumes received bytes (one-cycle `rx_valid` strobes with `rx_data`), parses 4-byte command frames, and updates the LED register. It also presents a status byte on `tx_data`, which the SPI slave shifts out on MISO during the next transaction. All logic runs in the SPI slave's clock domain.

## Interface
- `TIMEOUT_CYCLES`, 1024: `sclk` cycles allowed between bytes inside a frame before abort; ≥2.
- `NUM_LEDS`, 4: LED register width; ≤8.
- `sclk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cs` in 1: chip select, active-low; high = bus idle/frame boundary.
- `rx_valid` in 1: one-cycle strobe, `rx_data` holds a complete received byte.
- `rx_data` in 8: received byte.
- `leds` out NUM_LEDS: LED register.
- `tx_data` out 8: status byte for the slave's next transmission.
- `frame_ok` out 1: one-cycle pulse, frame executed.
- `frame_err` out 1: one-cycle pulse, frame rejected.
- `err_code` out 2: last error: 0 none, 1 bad checksum, 2 unknown command, 3 abort.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Frame format: SYNC (0xA5), CMD, DATA, CHK, where CHK = CMD ^ DATA. CHK is present only with checksum enabled.
- Commands:
  - 0x01 WRITE: `leds` = DATA[NUM_LEDS-1:0].
  - 0x02 SET: `leds` |= DATA.
  - 0x03 CLR: `leds` &= ~DATA.
  - 0x04 READ: `leds` unchanged.
- States and transitions:
  - IDLE→CMD on `rx_valid` with 0xA5 while `cs`=0. Non-sync bytes in IDLE are dropped silently; no error is flagged.
  - CMD→DATA on `rx_valid`; CMD is latched.
  - DATA→CHK on `rx_valid`; DATA is latched.
  - CHK→IDLE on `rx_valid`, then the frame is evaluated.
- Evaluation, in priority order:
  - Checksum mismatch → err 1.
  - CMD outside 0x01–0x04 → err 2.
  - Otherwise the command is executed.
- Success: `frame_ok`=1, `err_code`=0, `tx_data`={4'hA, zero-extended `leds` nibble (new value)}.
- Failure: `frame_err`=1, `err_code` set, `tx_data`=0xEE, `leds` unchanged.
- Abort from any non-IDLE state when `cs` goes high or the timeout expires: →IDLE, `frame_err`=1, err 3, `tx_data`=0xEE.
- Timeout counter: cleared on every accepted byte and in IDLE; increments otherwise; abort when count reaches TIMEOUT_CYCLES-1.
- Simultaneous events:
  - `cs`=1 together with `rx_valid`: the abort wins and the byte is dropped.
  - Timeout together with `rx_valid`: the byte wins and the counter clears.
- `cs` high while in IDLE: no effect.
- `rst` low mid-frame: immediate return to reset values; no pulse is generated.

## Timing
- Reset values: `leds`=0, `tx_data`=0x00, `frame_ok`=0, `frame_err`=0, `err_code`=0, `busy`=0, state IDLE, counter 0.
- Latency: the final frame byte is sampled at edge N. At that same edge N, `leds`, `tx_data`, `err_code` and the pulse all update (registered outputs), visible during cycle N+1.
- Pulses last exactly one cycle.
- `tx_data` and `err_code` hold their value until the next frame result or reset.
- Back-to-back frames are allowed: a SYNC byte in the cycle right after the final byte is accepted.

## Configuration
- `SPI_CMD_CHECKSUM_EN` defined: 4-byte frames, the CHK state exists, and err 1 is possible.
- Undefined:
  - 3-byte frames; DATA→IDLE and evaluation occur on the DATA byte.
  - The CHK state is absent and err 1 is never produced.
  - All other behaviour is identical.

## Structure
- Package `spi_cmd_pkg` holds:
  - The state enum (IDLE, CMD, DATA, CHK).
  - Command codes.
  - SYNC_BYTE=0xA5, ACK_NIBBLE=4'hA, ERR_BYTE=0xEE.
  - Error-code constants.
- Sub-module `spi_timeout_cnt`: parameterised counter with `clr`/`en` inputs and an `expired` output. It is instantiated once.

## Test plan
- Reset with `rst`=0 for 3 cycles → all outputs 0, `busy`=0.
- Frame A5,01,05,04 → `leds`=0101, `frame_ok` pulse, `tx_data`=0xA5; then A5,02,02,00 → `leds`=0111, `tx_data`=0xA7.
- Frame A5,03,01,FF (bad CHK) → `frame_err`, `err_code`=1, `tx_data`=0xEE, `leds` unchanged; then A5,07,00,07 → `err_code`=2.
- Frames with `cs` pulsed high after the CMD byte, and with TIMEOUT_CYCLES idle after SYNC → each gives `frame_err`, `err_code`=3, `busy`=0, `leds` unchanged.
- Bytes 0x00,0x13 in IDLE → no pulse, `busy`=0. `cs`=1 coincident with the final byte → abort, no execution.
- Build without `SPI_CMD_CHECKSUM_EN`: frame A5,01,0F → `leds`=1111, `frame_ok` one cycle after the DATA byte.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command frame decoder.
// The decoder checks a CHK byte only when the macro SPI_CMD_CHECKSUM_EN is defined.
package spi_cmd_pkg;

    // Frame parser states; CHK is only entered when the checksum byte is enabled
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } state_e;

    // Command codes carried in the CMD byte
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SET   = 8'h02;
    localparam logic [7:0] CMD_CLR   = 8'h03;
    localparam logic [7:0] CMD_READ  = 8'h04;

    // Framing and status bytes
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [3:0] ACK_NIBBLE = 4'hA;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM    = 2'd1;
    localparam logic [1:0] ERR_UNKNOWN_CMD = 2'd2;
    localparam logic [1:0] ERR_ABORT       = 2'd3;

    // True for the four command codes the decoder can execute
    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd >= CMD_WRITE) && (cmd <= CMD_READ);
    endfunction

endpackage

// File: rtl/spi_timeout_cnt.sv
// spi_timeout_cnt: inter-byte timeout counter. Clears on clr, counts on en and
// raises expired once the count reaches LIMIT-1. It holds there until cleared,
// so it never wraps back to a non-expired value.
module spi_timeout_cnt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == CNT_W'(LIMIT - 1));

    // Next count: clear wins, otherwise count up while enabled until expired
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses SYNC, CMD, DATA[, CHK] frames from the SPI slave byte
// stream, updates the LED register and publishes a status byte for the slave's
// next MISO transfer.
// Build option SPI_CMD_CHECKSUM_EN: 4-byte frames with CHK = CMD ^ DATA.
// Without it, frames are 3 bytes and are evaluated on the DATA byte.
// Handshake: a byte is consumed on any cycle with rx_valid=1 and cs=0. There is
// no backpressure, so every strobe is used, dropped (non-sync byte in IDLE) or
// discarded by an abort (cs=1 while a frame is open).
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned NUM_LEDS       = 4
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                cs,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic [NUM_LEDS-1:0] leds,
    output logic [7:0]          tx_data,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic                busy,
    output logic [1:0]          dbg_state
);

`ifdef SPI_CMD_CHECKSUM_EN
    localparam state_e LAST_ST = CHK;
`else
    localparam state_e LAST_ST = DATA;
`endif

    state_e              state_q;
    logic [7:0]          cmd_q;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]          data_q;
`endif
    logic [NUM_LEDS-1:0] leds_q;
    logic [NUM_LEDS-1:0] leds_d;
    logic [7:0]          tx_q;
    logic                ok_q;
    logic                err_q;
    logic [1:0]          code_q;

    logic                accept;
    logic                last_byte;
    logic                abort;
    logic                expired;
    logic                cnt_clr;
    logic                cnt_en;
    logic [7:0]          exec_data;
    logic [1:0]          eval_err;

    // A cs=1 strobe is never consumed. The timeout aborts only when no byte
    // arrives in the same cycle, so a late byte still rescues the frame.
    assign accept    = rx_valid && !cs;
    assign last_byte = accept && (state_q == LAST_ST);
    assign abort     = (state_q != IDLE) && (cs || (expired && !rx_valid));

    // The counter runs only while a frame is open and no byte or cs event is present
    assign cnt_clr = (state_q == IDLE) || rx_valid || cs;
    assign cnt_en  = !cnt_clr;

    spi_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (sclk),
        .rst_n  (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    // Frame evaluation on the final byte: error priority and the resulting LED value
    always_comb begin
`ifdef SPI_CMD_CHECKSUM_EN
        exec_data = data_q;
`else
        exec_data = rx_data;
`endif
        eval_err = ERR_NONE;
        if (!cmd_known(cmd_q)) begin
            eval_err = ERR_UNKNOWN_CMD;
        end
`ifdef SPI_CMD_CHECKSUM_EN
        // A bad checksum outranks an unknown command
        if (rx_data != (cmd_q ^ data_q)) begin
            eval_err = ERR_CHECKSUM;
        end
`endif
        case (cmd_q)
            CMD_WRITE: leds_d = exec_data[NUM_LEDS-1:0];
            CMD_SET:   leds_d = leds_q | exec_data[NUM_LEDS-1:0];
            CMD_CLR:   leds_d = leds_q & ~exec_data[NUM_LEDS-1:0];
            default:   leds_d = leds_q;
        endcase
    end

    // Frame FSM with registered result outputs (LEDs, status byte, pulses, error code)
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
            data_q  <= '0;
`endif
            leds_q  <= '0;
            tx_q    <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
                code_q  <= ERR_ABORT;
                tx_q    <= ERR_BYTE;
            end else if (last_byte) begin
                state_q <= IDLE;
                if (eval_err == ERR_NONE) begin
                    ok_q   <= 1'b1;
                    code_q <= ERR_NONE;
                    leds_q <= leds_d;
                    tx_q   <= {ACK_NIBBLE, 4'(leds_d)};
                end else begin
                    err_q  <= 1'b1;
                    code_q <= eval_err;
                    tx_q   <= ERR_BYTE;
                end
            end else if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= CMD;
                        end
                    end
                    CMD: begin
                        cmd_q   <= rx_data;
                        state_q <= DATA;
                    end
`ifdef SPI_CMD_CHECKSUM_EN
                    DATA: begin
                        data_q  <= rx_data;
                        state_q <= CHK;
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign leds      = leds_q;
    assign tx_data   = tx_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: bench for spi_cmd_decoder with directed vectors, corner
// sequences and random frames checked against a frame-level reference model.
// Works in both builds (SPI_CMD_CHECKSUM_EN defined or not).
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

    localparam int unsigned T_CYC = 16;
    localparam int unsigned NL    = 4;
    localparam int          W     = 1 + 1 + 2 + 8 + NL;
`ifdef SPI_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          sclk = 1'b0;
    logic          rst;
    logic          cs;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic [NL-1:0] leds;
    logic [7:0]    tx_data;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          busy;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  exp_q[$];
    logic [NL-1:0] m_leds;
    logic          prev_pulse;

    typedef struct {
        logic [7:0]    cmd;
        logic [7:0]    data;
        logic [7:0]    chk;
        logic [NL-1:0] exp_leds;
        logic [7:0]    exp_tx;
        logic [1:0]    exp_code;
        logic          exp_ok;
    } vec_t;

    vec_t vecs[5];

    spi_cmd_decoder #(
        .TIMEOUT_CYCLES(T_CYC),
        .NUM_LEDS      (NL)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .cs       (cs),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .leds     (leds),
        .tx_data  (tx_data),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic ok, input logic err, input logic [1:0] code,
                                          input logic [7:0] tx, input logic [NL-1:0] l);
        return {ok, err, code, tx, l};
    endfunction

    // ---------------- reference model (frame level) ----------------
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk);
        if (CHK_EN && (chk != (cmd ^ data))) begin
            exp_q.push_back(pack(1'b0, 1'b1, 2'd1, 8'hEE, m_leds));
        end else if (cmd < 8'h01 || cmd > 8'h04) begin
            exp_q.push_back(pack(1'b0, 1'b1, 2'd2, 8'hEE, m_leds));
        end else begin
            case (cmd)
                8'h01:   m_leds = data[NL-1:0];
                8'h02:   m_leds = m_leds | data[NL-1:0];
                8'h03:   m_leds = m_leds & ~data[NL-1:0];
                default: m_leds = m_leds;
            endcase
            exp_q.push_back(pack(1'b1, 1'b0, 2'd0, 8'hA0 | 8'(m_leds), m_leds));
        end
    endtask

    task automatic model_abort();
        exp_q.push_back(pack(1'b0, 1'b1, 2'd3, 8'hEE, m_leds));
    endtask

    // ---------------- driver tasks (entered/left #1 after a rising edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic cs_v);
        rx_data  = b;
        rx_valid = 1'b1;
        cs       = cs_v;
        @(posedge sclk);
        #1;
        rx_valid = 1'b0;
        cs       = 1'b0;
    endtask

    task automatic cs_pulse();
        cs = 1'b1;
        @(posedge sclk);
        #1;
        cs = 1'b0;
    endtask

    // Sends a complete frame; cs_last raises cs together with the final byte
    task automatic send_raw(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk,
                            input int gap_max, input logic cs_last);
        send_byte(8'hA5, 1'b0);
        idle($urandom_range(0, gap_max));
        send_byte(cmd, 1'b0);
        idle($urandom_range(0, gap_max));
        if (CHK_EN) begin
            send_byte(data, 1'b0);
            idle($urandom_range(0, gap_max));
            send_byte(chk, cs_last);
        end else begin
            send_byte(data, cs_last);
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk,
                              input int gap_max);
        model_frame(cmd, data, chk);
        send_raw(cmd, data, chk, gap_max, 1'b0);
        check("result_latency", 32'(frame_ok | frame_err), 32'd1);
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge sclk) begin
        if (!rst) begin
            prev_pulse = 1'b0;
        end else begin
            if (frame_ok || frame_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse actual ok=%0d err=%0d code=%0d required no pulse",
                             frame_ok, frame_err, err_code);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if ({frame_ok, frame_err, err_code, tx_data, leds} !== e) begin
                        failures++;
                        $display("FAIL scoreboard actual={ok,err,code,tx,leds}=0x%0h required=0x%0h",
                                 {frame_ok, frame_err, err_code, tx_data, leds}, e);
                    end
                end
                checks++;
                if (prev_pulse) begin
                    failures++;
                    $display("FAIL pulse_width actual=2+ cycles required=1 cycle");
                end
            end
            prev_pulse = frame_ok | frame_err;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        // Directed vectors, applied back to back in order
`ifdef SPI_CMD_CHECKSUM_EN
        vecs[0] = '{8'h01, 8'h05, 8'h04, 4'b0101, 8'hA5, 2'd0, 1'b1};
        vecs[1] = '{8'h02, 8'h02, 8'h00, 4'b0111, 8'hA7, 2'd0, 1'b1};
        vecs[2] = '{8'h03, 8'h01, 8'hFF, 4'b0111, 8'hEE, 2'd1, 1'b0};
        vecs[3] = '{8'h07, 8'h00, 8'h07, 4'b0111, 8'hEE, 2'd2, 1'b0};
`else
        vecs[0] = '{8'h01, 8'h05, 8'h04, 4'b0101, 8'hA5, 2'd0, 1'b1};
        vecs[1] = '{8'h02, 8'h02, 8'h00, 4'b0111, 8'hA7, 2'd0, 1'b1};
        vecs[2] = '{8'h03, 8'h01, 8'hFF, 4'b0110, 8'hA6, 2'd0, 1'b1};
        vecs[3] = '{8'h07, 8'h00, 8'h07, 4'b0110, 8'hEE, 2'd2, 1'b0};
`endif
        vecs[4] = '{8'h01, 8'h0F, 8'h0E, 4'b1111, 8'hAF, 2'd0, 1'b1};

        // Reset
        rst      = 1'b0;
        cs       = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_leds   = '0;
        repeat (3) @(posedge sclk);
        #1;
        check("reset_leds", 32'(leds), 32'd0);
        check("reset_tx", 32'(tx_data), 32'h00);
        check("reset_ok", 32'(frame_ok), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_code", 32'(err_code), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        cs  = 1'b0;
        idle(1);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pack(vecs[i].exp_ok, !vecs[i].exp_ok, vecs[i].exp_code,
                                 vecs[i].exp_tx, vecs[i].exp_leds));
            send_raw(vecs[i].cmd, vecs[i].data, vecs[i].chk, 0, 1'b0);
            check("vec_pulse", 32'({frame_ok, frame_err}), 32'({vecs[i].exp_ok, !vecs[i].exp_ok}));
            check("vec_leds", 32'(leds), 32'(vecs[i].exp_leds));
            check("vec_tx", 32'(tx_data), 32'(vecs[i].exp_tx));
            check("vec_code", 32'(err_code), 32'(vecs[i].exp_code));
            m_leds = vecs[i].exp_leds;
        end
        idle(1);
        check("ok_one_cycle", 32'(frame_ok | frame_err), 32'd0);

        // cs raised after the CMD byte
        model_abort();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        cs_pulse();
        check("cs_abort_busy", 32'(busy), 32'd0);
        check("cs_abort_code", 32'(err_code), 32'd3);
        check("cs_abort_tx", 32'(tx_data), 32'hEE);
        check("cs_abort_leds", 32'(leds), 32'(m_leds));

        // Timeout after SYNC with no further bytes
        model_abort();
        send_byte(8'hA5, 1'b0);
        idle(T_CYC - 1);
        check("timeout_not_early", 32'(busy), 32'd1);
        idle(1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_code", 32'(err_code), 32'd3);
        check("timeout_leds", 32'(leds), 32'(m_leds));

        // A byte arriving on the timeout cycle is accepted
        model_frame(8'h03, 8'h01, 8'h02);
        send_byte(8'hA5, 1'b0);
        idle(T_CYC - 1);
        send_byte(8'h03, 1'b0);
        if (CHK_EN) begin
            send_byte(8'h01, 1'b0);
            send_byte(8'h02, 1'b0);
        end else begin
            send_byte(8'h01, 1'b0);
        end
        check("late_byte_code", 32'(err_code), 32'd0);
        check("late_byte_leds", 32'(leds), 32'(m_leds));

        // Non-sync bytes in IDLE are dropped silently
        send_byte(8'h00, 1'b0);
        check("garbage0_busy", 32'(busy), 32'd0);
        send_byte(8'h13, 1'b0);
        check("garbage1_busy", 32'(busy), 32'd0);
        idle(1);

        // cs high together with the final byte: abort, no execution
        model_abort();
        send_raw(8'h01, 8'h00, 8'h01, 0, 1'b1);
        check("cs_final_code", 32'(err_code), 32'd3);
        check("cs_final_leds", 32'(leds), 32'(m_leds));

        // Reset in the middle of a frame
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_leds", 32'(leds), 32'd0);
        check("midrst_tx", 32'(tx_data), 32'h00);
        idle(2);
        rst    = 1'b1;
        m_leds = '0;
        idle(2);
        check("midrst_code", 32'(err_code), 32'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic [7:0]  c;
            logic [7:0]  d;
            logic [7:0]  b;
            kind = $urandom_range(0, 9);
            c    = 8'($urandom_range(1, 4));
            d    = 8'($urandom_range(0, 255));
            if (kind <= 5) begin
                send_frame(c, d, c ^ d, 3);
            end else if (kind == 6) begin
                send_frame(c, d, c ^ d ^ 8'($urandom_range(1, 255)), 3);
            end else if (kind == 7) begin
                c = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
                send_frame(c, d, c ^ d, 3);
            end else if (kind == 8) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 1'b0);
                check("rand_garbage_busy", 32'(busy), 32'd0);
            end else begin
                model_abort();
                send_byte(8'hA5, 1'b0);
                if ($urandom_range(0, 1) == 1) send_byte(c, 1'b0);
                idle($urandom_range(0, 3));
                cs_pulse();
                check("rand_abort_busy", 32'(busy), 32'd0);
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_leds", 32'(leds), 32'(m_leds));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
